// File: rtl/alu_pkg.sv
// Shared definitions for alu_seq: funct codes, FSM state encoding and
// sign-magnitude helpers.
package alu_pkg;

    localparam int WMAX = 128;
    typedef logic [WMAX-1:0] wide_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Base ops are decoded on funct_alu[2:0]; bit 3 selects SUB / SRA.
    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_XOR = 3'b100;
    localparam logic [2:0] F3_SR  = 3'b101;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;

    localparam logic [2:0] M_MUL    = 3'b000;
    localparam logic [2:0] M_MULH   = 3'b001;
    localparam logic [2:0] M_MULHSU = 3'b010;
    localparam logic [2:0] M_MULHU  = 3'b011;
    localparam logic [2:0] M_DIV    = 3'b100;
    localparam logic [2:0] M_DIVU   = 3'b101;
    localparam logic [2:0] M_REM    = 3'b110;
    localparam logic [2:0] M_REMU   = 3'b111;

    // Two's-complement negate when neg is set; callers truncate to their width.
    function automatic wide_t cond_neg(input wide_t v, input logic neg);
        return neg ? (~v + wide_t'(1)) : v;
    endfunction

endpackage

// File: rtl/alu_seq_div.sv
// Iterative restoring divider on magnitudes, one quotient bit per cycle.
// done is combinational in the final iteration cycle, with signed results.
module alu_seq_div
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            abort,
    input  logic            start,
    input  logic            is_signed,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            done,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    localparam int CNT_W = $clog2(XLEN) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN);

    logic            busy_q;
    logic [CNT_W-1:0] cnt_q, cnt_step;
    logic [XLEN-1:0] quo_q, rem_q, dvs_q;
    logic [XLEN-1:0] quo_step, rem_step;
    logic            negq_q, negr_q;
    logic            s1, s2;
    logic [XLEN:0]   shifted, trial;

    always_comb begin
        s1        = is_signed & dividend[XLEN-1];
        s2        = is_signed & divisor[XLEN-1];
        shifted   = {rem_q, quo_q[XLEN-1]};
        trial     = shifted - {1'b0, dvs_q};
        rem_step  = trial[XLEN] ? shifted[XLEN-1:0] : trial[XLEN-1:0];
        quo_step  = {quo_q[XLEN-2:0], ~trial[XLEN]};
        cnt_step  = cnt_q + CNT_W'(1);
        done      = busy_q && (cnt_step == CNT_LAST);
        // Quotient sign is sign1^sign2; remainder follows the dividend.
        quotient  = XLEN'(cond_neg(wide_t'(quo_step), negq_q));
        remainder = XLEN'(cond_neg(wide_t'(rem_step), negr_q));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            quo_q  <= '0;
            rem_q  <= '0;
            dvs_q  <= '0;
            negq_q <= 1'b0;
            negr_q <= 1'b0;
        end else if (abort) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
        end else if (start) begin
            busy_q <= 1'b1;
            cnt_q  <= '0;
            quo_q  <= XLEN'(cond_neg(wide_t'(dividend), s1));
            rem_q  <= '0;
            dvs_q  <= XLEN'(cond_neg(wide_t'(divisor), s2));
            negq_q <= s1 ^ s2;
            negr_q <= s1;
        end else if (busy_q) begin
            quo_q <= quo_step;
            rem_q <= rem_step;
            cnt_q <= cnt_step;
            if (done) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked RV ALU with iterative M-extension; optional ALU_SEQ_FAST_MUL_EN
// replaces the shift-add multiplier with a single-cycle multiply.
//   state  | meaning
//   IDLE   | waiting for a request (in_ready=1)
//   MUL    | shift-add multiply iterating (busy=1)
//   DIV    | restoring divider iterating (busy=1)
//   DONE   | result held on aluout (out_valid=1)
module alu_seq
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] aluin1,
    input  logic [XLEN-1:0] aluin2,
    input  logic [3:0]      funct_alu,
    input  logic            mext,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] aluout,
    output logic            busy
);

    localparam int SHAMT_W = $clog2(XLEN);
    localparam int PW      = 2 * XLEN;
    localparam logic [SHAMT_W:0] CNT_LAST = (SHAMT_W+1)'(XLEN);
    localparam logic [XLEN-1:0]  MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t           state_q, state_d;
    logic [XLEN-1:0]  result_q, result_d;
    logic [XLEN-1:0]  mcand_q, mcand_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [SHAMT_W:0] cnt_q, cnt_d, cnt_step;
    logic             neg_q, neg_d;
    logic             sel_q, sel_d;

    logic                   accept;
    logic [2:0]             f3;
    logic [SHAMT_W-1:0]     shamt;
    logic [XLEN-1:0]        base_res;
    logic signed [XLEN-1:0] sra_res;
    logic                   m_s1, m_s2, mul_hi, d_signed, d_rem;
    logic                   div_zero, div_ovf, div_start, div_done;
    logic [XLEN-1:0]        div_quo, div_rem, addend;
    logic [XLEN:0]          msum;
    logic [PW-1:0]          acc_step, mprod;
`ifdef ALU_SEQ_FAST_MUL_EN
    logic [PW-1:0]          fa, fb, fprod;
`endif

    assign in_ready  = (state_q == S_IDLE) || (state_q == S_DONE && out_ready);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q == S_MUL) || (state_q == S_DIV);
    assign aluout    = result_q;
    assign accept    = in_valid && in_ready && !flush;

    always_comb begin
        f3       = funct_alu[2:0];
        shamt    = aluin2[SHAMT_W-1:0];
        sra_res  = $signed(aluin1) >>> shamt;
        case (f3)
            F3_ADD:  base_res = funct_alu[3] ? (aluin1 - aluin2) : (aluin1 + aluin2);
            F3_SLL:  base_res = aluin1 << shamt;
            F3_XOR:  base_res = aluin1 ^ aluin2;
            F3_SR:   base_res = funct_alu[3] ? sra_res : (aluin1 >> shamt);
            F3_OR:   base_res = aluin1 | aluin2;
            F3_AND:  base_res = aluin1 & aluin2;
            default: base_res = '0;
        endcase

        m_s1     = aluin1[XLEN-1] & ((f3 == M_MULH) || (f3 == M_MULHSU));
        m_s2     = aluin2[XLEN-1] & (f3 == M_MULH);
        mul_hi   = (f3 != M_MUL);
        d_signed = (f3 == M_DIV) || (f3 == M_REM);
        d_rem    = (f3 == M_REM) || (f3 == M_REMU);
        div_zero = (aluin2 == '0);
        div_ovf  = d_signed && (aluin1 == MOST_NEG) && (aluin2 == {XLEN{1'b1}});

        addend   = acc_q[0] ? mcand_q : {XLEN{1'b0}};
        msum     = {1'b0, acc_q[PW-1:XLEN]} + {1'b0, addend};
        acc_step = {msum, acc_q[XLEN-1:1]};
        mprod    = PW'(cond_neg(wide_t'(acc_step), neg_q));
        cnt_step = cnt_q + (SHAMT_W+1)'(1);
`ifdef ALU_SEQ_FAST_MUL_EN
        fa       = {{XLEN{m_s1}}, aluin1};
        fb       = {{XLEN{m_s2}}, aluin2};
        fprod    = fa * fb;
`endif
    end

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        sel_d     = sel_q;
        div_start = 1'b0;

        case (state_q)
            S_MUL: begin
                acc_d = acc_step;
                cnt_d = cnt_step;
                if (cnt_step == CNT_LAST) begin
                    result_d = sel_q ? mprod[PW-1:XLEN] : mprod[XLEN-1:0];
                    state_d  = S_DONE;
                end
            end
            S_DIV: begin
                if (div_done) begin
                    result_d = sel_q ? div_rem : div_quo;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: ;
        endcase

        if (accept) begin
            if (!mext) begin
                result_d = base_res;
                state_d  = S_DONE;
            end else if (!f3[2]) begin
`ifdef ALU_SEQ_FAST_MUL_EN
                result_d = mul_hi ? fprod[PW-1:XLEN] : fprod[XLEN-1:0];
                state_d  = S_DONE;
`else
                mcand_d = XLEN'(cond_neg(wide_t'(aluin1), m_s1));
                acc_d   = {{XLEN{1'b0}}, XLEN'(cond_neg(wide_t'(aluin2), m_s2))};
                neg_d   = m_s1 ^ m_s2;
                sel_d   = mul_hi;
                cnt_d   = '0;
                state_d = S_MUL;
`endif
            end else if (div_zero) begin
                result_d = d_rem ? aluin1 : {XLEN{1'b1}};
                state_d  = S_DONE;
            end else if (div_ovf) begin
                result_d = d_rem ? {XLEN{1'b0}} : MOST_NEG;
                state_d  = S_DONE;
            end else begin
                div_start = 1'b1;
                sel_d     = d_rem;
                state_d   = S_DIV;
            end
        end

        // Redirect wins over everything, including a same-cycle request.
        if (flush) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            mcand_q  <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            sel_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            sel_q    <= sel_d;
        end
    end

    alu_seq_div #(.XLEN(XLEN)) u_div (
        .clk       (clk),
        .rst       (rst),
        .abort     (flush),
        .start     (div_start),
        .is_signed (d_signed),
        .dividend  (aluin1),
        .divisor   (aluin2),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

endmodule
